// File: rtl/oled_cmd_sequencer_pkg.sv
// Shared constants for the SSD1306 power-up sequencer: command opcodes, control bytes,
// FSM state encoding and the transmit beat payload.
package oled_cmd_sequencer_pkg;

  localparam int unsigned INIT_LEN = 25;
  localparam int unsigned IDX_W    = 11;
  localparam int unsigned ROM_AW   = 5;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  localparam logic [7:0] SSD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] SSD_CLK_DIV      = 8'hD5;
  localparam logic [7:0] SSD_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] SSD_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] SSD_START_LINE   = 8'h40;
  localparam logic [7:0] SSD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] SSD_MEM_MODE     = 8'h20;
  localparam logic [7:0] SSD_SEG_REMAP    = 8'hA1;
  localparam logic [7:0] SSD_COM_SCAN_DEC = 8'hC8;
  localparam logic [7:0] SSD_COM_PINS     = 8'hDA;
  localparam logic [7:0] SSD_CONTRAST     = 8'h81;
  localparam logic [7:0] SSD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] SSD_VCOMH        = 8'hDB;
  localparam logic [7:0] SSD_RESUME_RAM   = 8'hA4;
  localparam logic [7:0] SSD_NORMAL       = 8'hA6;
  localparam logic [7:0] SSD_DISPLAY_ON   = 8'hAF;

  localparam logic [3:0] S_PWR_WAIT  = 4'd0;
  localparam logic [3:0] S_CMD_START = 4'd1;
  localparam logic [3:0] S_CMD_SEND  = 4'd2;
  localparam logic [3:0] S_CMD_WAIT  = 4'd3;
  localparam logic [3:0] S_CLR_START = 4'd4;
  localparam logic [3:0] S_CLR_SEND  = 4'd5;
  localparam logic [3:0] S_CLR_WAIT  = 4'd6;
  localparam logic [3:0] S_RETRY     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_beat_t;

  function automatic logic [7:0] addr_wr_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/oled_cmd_sequencer_if.sv
// Byte-stream link between the OLED sequencer (master) and the I2C engine (slave).
interface oled_cmd_sequencer_if;
  logic       i2c_start;
  logic [7:0] i2c_tx_data;
  logic       i2c_tx_valid;
  logic       i2c_tx_ready;
  logic       i2c_tx_last;
  logic       i2c_busy;
  logic       i2c_done;
  logic       i2c_ack_err;

  modport master (
    output i2c_start, i2c_tx_data, i2c_tx_valid, i2c_tx_last,
    input  i2c_tx_ready, i2c_busy, i2c_done, i2c_ack_err
  );

  modport slave (
    input  i2c_start, i2c_tx_data, i2c_tx_valid, i2c_tx_last,
    output i2c_tx_ready, i2c_busy, i2c_done, i2c_ack_err
  );
endinterface

// File: rtl/oled_cmd_sequencer_init_rom.sv
// SSD1306 128x64 init command list, combinational lookup by position.
module oled_init_rom
  import oled_cmd_sequencer_pkg::*;
(
  input  logic [ROM_AW-1:0] idx,
  output logic [7:0]        data_c
);

  always_comb begin
    data_c = 8'h00;
    case (idx)
      5'd0:  data_c = SSD_DISPLAY_OFF;
      5'd1:  data_c = SSD_CLK_DIV;
      5'd2:  data_c = 8'h80;
      5'd3:  data_c = SSD_MUX_RATIO;
      5'd4:  data_c = 8'h3F;
      5'd5:  data_c = SSD_DISP_OFFSET;
      5'd6:  data_c = 8'h00;
      5'd7:  data_c = SSD_START_LINE;
      5'd8:  data_c = SSD_CHARGE_PUMP;
      5'd9:  data_c = 8'h14;
      5'd10: data_c = SSD_MEM_MODE;
      5'd11: data_c = 8'h00;
      5'd12: data_c = SSD_SEG_REMAP;
      5'd13: data_c = SSD_COM_SCAN_DEC;
      5'd14: data_c = SSD_COM_PINS;
      5'd15: data_c = 8'h12;
      5'd16: data_c = SSD_CONTRAST;
      5'd17: data_c = 8'hCF;
      5'd18: data_c = SSD_PRECHARGE;
      5'd19: data_c = 8'hF1;
      5'd20: data_c = SSD_VCOMH;
      5'd21: data_c = 8'h40;
      5'd22: data_c = SSD_RESUME_RAM;
      5'd23: data_c = SSD_NORMAL;
      5'd24: data_c = SSD_DISPLAY_ON;
      default: data_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Power-up sequencer for the SSD1306: waits, sends the init list, clears GDDRAM,
// retries NACKed transactions and reports status on the board LEDs.
module oled_cmd_sequencer
  import oled_cmd_sequencer_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 1_000_000,
  parameter logic [6:0]  OLED_ADDR    = 7'h3C,
  parameter int unsigned CLR_BYTES    = 1024,
  parameter logic [7:0]  FILL_BYTE    = 8'h00,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  oled_cmd_sequencer_if.master bus,
  output logic                 busy,
  output logic                 init_done,
  output logic                 oled_err
);

  localparam int unsigned PWR_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] CMD_END  = IDX_W'(INIT_LEN + 1);
  localparam logic [IDX_W-1:0] CLR_END  = IDX_W'(CLR_BYTES + 1);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic [3:0]       state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             clr_q, clr_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  tx_beat_t         beat_q, beat_d;
  logic             busy_q, busy_d;
  logic             init_done_q, init_done_d;
  logic             oled_err_q, oled_err_d;

  logic             in_send_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic [IDX_W-1:0] end_idx_c;
  logic [ROM_AW-1:0] rom_idx_c;
  logic [7:0]       rom_data_c;
  tx_beat_t         nxt_beat_c;

  oled_init_rom u_rom (
    .idx    (rom_idx_c),
    .data_c (rom_data_c)
  );

  // Beat for the byte after the current one (or byte 0 when a transaction starts).
  always_comb begin
    nxt_beat_c = '0;
    in_send_c  = (state_q == S_CMD_SEND) || (state_q == S_CLR_SEND);
    sel_idx_c  = in_send_c ? idx_q + IDX_W'(1) : '0;
    end_idx_c  = clr_q ? CLR_END : CMD_END;
    rom_idx_c  = ROM_AW'(sel_idx_c - IDX_W'(2));
    if (sel_idx_c == '0) begin
      nxt_beat_c.data = addr_wr_byte(OLED_ADDR);
    end else if (sel_idx_c == IDX_W'(1)) begin
      nxt_beat_c.data = clr_q ? CTRL_DATA : CTRL_CMD;
    end else begin
      nxt_beat_c.data = clr_q ? FILL_BYTE : rom_data_c;
    end
    nxt_beat_c.last = (sel_idx_c == end_idx_c);
  end

  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    clr_d     = clr_q;
    start_d   = 1'b0;
    valid_d   = valid_q;
    beat_d    = beat_q;

    case (state_q)
      S_PWR_WAIT: begin
        if (pwr_cnt_q == PWR_LAST) state_d = S_CMD_START;
        else                       pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
      end
      S_CMD_START, S_CLR_START: begin
        if (!bus.i2c_busy) begin
          start_d = 1'b1;
          idx_d   = '0;
          valid_d = 1'b1;
          beat_d  = nxt_beat_c;
          state_d = clr_q ? S_CLR_SEND : S_CMD_SEND;
        end
      end
      S_CMD_SEND, S_CLR_SEND: begin
        // An early done is the master aborting on NACK: retry without waiting.
        if (bus.i2c_done) begin
          valid_d = 1'b0;
          beat_d  = '0;
          state_d = S_RETRY;
        end else if (valid_q && bus.i2c_tx_ready) begin
          if (beat_q.last) begin
            valid_d = 1'b0;
            beat_d  = '0;
            state_d = clr_q ? S_CLR_WAIT : S_CMD_WAIT;
          end else begin
            idx_d  = sel_idx_c;
            beat_d = nxt_beat_c;
          end
        end
      end
      S_CMD_WAIT, S_CLR_WAIT: begin
        if (bus.i2c_done) begin
          if (bus.i2c_ack_err) begin
            state_d = S_RETRY;
          end else begin
            retry_d = '0;
            clr_d   = 1'b1;
            state_d = clr_q ? S_DONE : S_CLR_START;
          end
        end
      end
      S_RETRY: begin
        if (retry_q == RTY_MAX) begin
          state_d = S_ERR;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          state_d = clr_q ? S_CLR_START : S_CMD_START;
        end
      end
      S_DONE, S_ERR: ;
      default: state_d = S_PWR_WAIT;
    endcase

    busy_d      = (state_d != S_DONE) && (state_d != S_ERR);
    init_done_d = (state_d == S_DONE);
    oled_err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PWR_WAIT;
      pwr_cnt_q   <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      clr_q       <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      beat_q      <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      oled_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      clr_q       <= clr_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      oled_err_q  <= oled_err_d;
    end
  end

  assign bus.i2c_start    = start_q;
  assign bus.i2c_tx_valid = valid_q;
  assign bus.i2c_tx_data  = beat_q.data;
  assign bus.i2c_tx_last  = beat_q.last;
  assign busy             = busy_q;
  assign init_done        = init_done_q;
  assign oled_err         = oled_err_q;

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Bench for oled_cmd_sequencer: byte-level I2C master model with random ready/done timing,
// expected byte streams built from the SSD1306 init list and clear rules.
module tb_oled_cmd_sequencer;

  localparam int unsigned PWRUP = 100;
  localparam int unsigned CLR_N = 1024;

  logic clk = 1'b0;
  logic reset_n;
  logic busy, init_done, oled_err;

  oled_cmd_sequencer_if bus();

  oled_cmd_sequencer #(
    .PWRUP_CYCLES (PWRUP),
    .OLED_ADDR    (7'h3C),
    .CLR_BYTES    (CLR_N),
    .FILL_BYTE    (8'h00),
    .MAX_RETRY    (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .init_done (init_done),
    .oled_err  (oled_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference streams
  logic [7:0] init_list [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [7:0] exp_cmd[$];
  logic [7:0] exp_clr[$];

  // Master model state and policy
  bit         ready_slow;
  int         nack_addr_left;
  bit         nack_clr;
  int         n_starts, n_cmd, n_clr, n_aborts;
  bit         m_active, m_ended, m_nack;
  int         m_cd, m_gaps, m_last_cnt, m_last_pos;
  logic [7:0] m_cur[$];
  logic [7:0] cmd_log[$];
  logic [7:0] clr_log[$];
  int         cmd_last_cnt, cmd_last_pos, cmd_gaps;
  int         clr_last_cnt, clr_last_pos, clr_gaps;

  initial begin
    bus.i2c_tx_ready = 1'b0;
    bus.i2c_busy     = 1'b0;
    bus.i2c_done     = 1'b0;
    bus.i2c_ack_err  = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_done     = 1'b0;
      bus.i2c_ack_err  = 1'b0;
      bus.i2c_tx_ready = 1'b0;
      if (!reset_n) begin
        m_active = 0; m_ended = 0; m_cd = 0; m_nack = 0;
        bus.i2c_busy = 1'b0;
        m_cur.delete();
      end else begin
        if (bus.i2c_start) begin
          n_starts++;
          m_active = 1; m_ended = 0; m_cd = 0; m_nack = 0;
          m_gaps = 0; m_last_cnt = 0; m_last_pos = -1;
          m_cur.delete();
          bus.i2c_busy = 1'b1;
        end
        if (m_active && m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) begin
            bus.i2c_done    = 1'b1;
            bus.i2c_ack_err = m_nack;
            bus.i2c_busy    = 1'b0;
            m_active = 0;
          end
        end else if (m_active && !m_ended) begin
          if (bus.i2c_tx_valid) begin
            bus.i2c_tx_ready = ready_slow ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (bus.i2c_tx_ready) begin
              if (bus.i2c_tx_last) begin
                m_last_cnt++;
                m_last_pos = m_cur.size();
              end
              m_cur.push_back(bus.i2c_tx_data);
              if (m_cur.size() == 1 && nack_addr_left > 0) begin
                nack_addr_left--;
                n_aborts++;
                m_nack = 1; m_ended = 1; m_cd = $urandom_range(2, 4);
              end else if (bus.i2c_tx_last) begin
                if (m_cur.size() >= 2 && m_cur[1] == 8'h40) begin
                  n_clr++;
                  clr_log = m_cur; clr_last_cnt = m_last_cnt; clr_last_pos = m_last_pos; clr_gaps = m_gaps;
                  m_nack = nack_clr;
                end else begin
                  n_cmd++;
                  cmd_log = m_cur; cmd_last_cnt = m_last_cnt; cmd_last_pos = m_last_pos; cmd_gaps = m_gaps;
                  m_nack = 0;
                end
                m_ended = 1; m_cd = $urandom_range(1, 4);
              end
            end
          end else if (m_cur.size() > 0) begin
            m_gaps++;
          end
        end
      end
    end
  end

  task automatic build_ref();
    exp_cmd.delete(); exp_clr.delete();
    exp_cmd.push_back(8'h78); exp_cmd.push_back(8'h00);
    foreach (init_list[i]) exp_cmd.push_back(init_list[i]);
    exp_clr.push_back(8'h78); exp_clr.push_back(8'h40);
    for (int i = 0; i < int'(CLR_N); i++) exp_clr.push_back(8'h00);
  endtask

  task automatic reset_seq(input bit slow, input int naddr, input bit nclr);
    @(negedge clk);
    reset_n = 1'b0;
    ready_slow = slow; nack_addr_left = naddr; nack_clr = nclr;
    repeat (5) @(negedge clk);
    n_starts = 0; n_cmd = 0; n_clr = 0; n_aborts = 0;
    cmd_log.delete(); clr_log.delete();
    cmd_last_cnt = 0; cmd_last_pos = -1; cmd_gaps = 0;
    clr_last_cnt = 0; clr_last_pos = -1; clr_gaps = 0;
    reset_n = 1'b1;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done || oled_err) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    int k;
    @(negedge clk);
    reset_n = 1'b0;
    ready_slow = 0; nack_addr_left = 0; nack_clr = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, init_done, oled_err, bus.i2c_start, bus.i2c_tx_valid, bus.i2c_tx_last} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 100000 (busy,done,err,start,valid,last)",
        {busy, init_done, oled_err, bus.i2c_start, bus.i2c_tx_valid, bus.i2c_tx_last});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 50) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pwrup_busy: got %b want 1", busy); end
      end
      if (bus.i2c_start) begin k = i; break; end
    end
    n_checks++;
    if (!(k >= int'(PWRUP) && k <= int'(PWRUP) + 5)) begin
      n_fail++; $display("FAIL first_start_cycle: got %0d want %0d..%0d", k, PWRUP, PWRUP + 5);
    end
  endtask

  task automatic test_happy(input bit slow, input string tag);
    bit ok;
    int bad;
    reset_seq(slow, 0, 0);
    wait_end(20000, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: no end state within budget", tag); end
    n_checks++;
    if ({init_done, oled_err, busy} !== 3'b100) begin
      n_fail++; $display("FAIL %s_status: got %b want 100 (done,err,busy)", tag, {init_done, oled_err, busy});
    end
    n_checks++;
    if (cmd_log.size() != exp_cmd.size()) begin
      n_fail++; $display("FAIL %s_cmd_len: got %0d want %0d", tag, cmd_log.size(), exp_cmd.size());
    end
    bad = 0;
    for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++) if (cmd_log[i] !== exp_cmd[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_cmd_bytes: %0d bytes differ, want 0", tag, bad); end
    n_checks++;
    if (cmd_last_cnt != 1 || cmd_last_pos != exp_cmd.size() - 1) begin
      n_fail++; $display("FAIL %s_cmd_last: got cnt %0d pos %0d want cnt 1 pos %0d", tag, cmd_last_cnt, cmd_last_pos, exp_cmd.size() - 1);
    end
    n_checks++;
    if (clr_log.size() != exp_clr.size()) begin
      n_fail++; $display("FAIL %s_clr_len: got %0d want %0d", tag, clr_log.size(), exp_clr.size());
    end
    bad = 0;
    for (int i = 0; i < exp_clr.size() && i < clr_log.size(); i++) if (clr_log[i] !== exp_clr[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_clr_bytes: %0d bytes differ, want 0", tag, bad); end
    n_checks++;
    if (clr_last_cnt != 1 || clr_last_pos != exp_clr.size() - 1) begin
      n_fail++; $display("FAIL %s_clr_last: got cnt %0d pos %0d want cnt 1 pos %0d", tag, clr_last_cnt, clr_last_pos, exp_clr.size() - 1);
    end
    n_checks++;
    if (n_starts != 2 || n_cmd != 1 || n_clr != 1) begin
      n_fail++; $display("FAIL %s_txn_count: got starts %0d cmd %0d clr %0d want 2 1 1", tag, n_starts, n_cmd, n_clr);
    end
    if (!slow) begin
      n_checks++;
      if (cmd_gaps + clr_gaps != 0) begin
        n_fail++; $display("FAIL %s_bubbles: got %0d valid-low cycles mid-stream want 0", tag, cmd_gaps + clr_gaps);
      end
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_starts != 2 || init_done !== 1'b1) begin
      n_fail++; $display("FAIL %s_quiet_after_done: got starts %0d done %b want 2 1", tag, n_starts, init_done);
    end
  endtask

  task automatic test_nack_retry();
    bit ok;
    int bad;
    reset_seq($urandom_range(0, 1) == 1, 2, 0);
    wait_end(20000, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL nack_timeout: no end state within budget"); end
    n_checks++;
    if (n_aborts != 2 || n_starts != 4 || n_cmd != 1 || n_clr != 1) begin
      n_fail++; $display("FAIL nack_txns: got aborts %0d starts %0d cmd %0d clr %0d want 2 4 1 1", n_aborts, n_starts, n_cmd, n_clr);
    end
    n_checks++;
    if ({init_done, oled_err, busy} !== 3'b100) begin
      n_fail++; $display("FAIL nack_status: got %b want 100 (done,err,busy)", {init_done, oled_err, busy});
    end
    bad = (cmd_log.size() != exp_cmd.size()) ? 1 : 0;
    for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++) if (cmd_log[i] !== exp_cmd[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL nack_cmd_stream: %0d differences want 0", bad); end
  endtask

  task automatic test_clr_exhaust();
    bit ok;
    int snap;
    reset_seq(0, 0, 1);
    wait_end(20000, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL exhaust_timeout: no end state within budget"); end
    n_checks++;
    if (n_clr != 4 || n_cmd != 1 || n_starts != 5) begin
      n_fail++; $display("FAIL exhaust_txns: got clr %0d cmd %0d starts %0d want 4 1 5", n_clr, n_cmd, n_starts);
    end
    n_checks++;
    if ({init_done, oled_err, busy} !== 3'b010) begin
      n_fail++; $display("FAIL exhaust_status: got %b want 010 (done,err,busy)", {init_done, oled_err, busy});
    end
    snap = n_starts;
    repeat (50) @(negedge clk);
    n_checks++;
    if (n_starts != snap || oled_err !== 1'b1 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL exhaust_sticky: got starts %0d err %b done %b want %0d 1 0", n_starts, oled_err, init_done, snap);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int k;
    reset_seq(0, 0, 0);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_cur.size() >= 500 && m_cur[1] == 8'h40) begin ok = 1; break; end
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_reach: clear byte 500 not reached"); end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, init_done, oled_err, bus.i2c_start, bus.i2c_tx_valid, bus.i2c_tx_last} !== 6'b100000) begin
      n_fail++; $display("FAIL midrst_outputs: got %b want 100000 (busy,done,err,start,valid,last)",
        {busy, init_done, oled_err, bus.i2c_start, bus.i2c_tx_valid, bus.i2c_tx_last});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.i2c_start) begin k = i; break; end
    end
    n_checks++;
    if (!(k >= int'(PWRUP) && k <= int'(PWRUP) + 5)) begin
      n_fail++; $display("FAIL midrst_restart_cycle: got %0d want %0d..%0d", k, PWRUP, PWRUP + 5);
    end
    wait_end(20000, ok);
    n_checks++;
    if (ok !== 1'b1 || init_done !== 1'b1 || n_cmd != 2 || n_clr != 1 || clr_log.size() != exp_clr.size()) begin
      n_fail++; $display("FAIL midrst_complete: got ok %b done %b cmd %0d clr %0d clrlen %0d want 1 1 2 1 %0d",
        ok, init_done, n_cmd, n_clr, clr_log.size(), exp_clr.size());
    end
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    build_ref();
    test_reset();
    test_happy(0, "happy");
    test_happy(1, "throttle");
    test_nack_retry();
    test_clr_exhaust();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
